// File: rtl/lcd_cmd_sched.sv
// Arbitrates two clients onto a character-LCD controller: boots the panel with INIT,
// then issues SEND_DATA/CLEAR commands round-robin with ready-handshake timeouts.
module lcd_cmd_sched #(
    parameter int ACK_CYCLES  = 8,
    parameter int DONE_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       op0,
    input  logic       op1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       ctrl_rdy,
    output logic [5:0] cmd_out,
    output logic [7:0] data_out,
    output logic       done,
    output logic       done_id,
    output logic       err,
    output logic       boot_ok
);

    typedef enum logic [2:0] {
        S_BOOT_ISSUE = 3'd0,
        S_BOOT_WAIT  = 3'd1,
        S_IDLE       = 3'd2,
        S_ISSUE      = 3'd3,
        S_WAIT_ACK   = 3'd4,
        S_WAIT_DONE  = 3'd5,
        S_RELEASE    = 3'd6
    } state_t;

    localparam int MAXC = (ACK_CYCLES > DONE_CYCLES) ? ACK_CYCLES : DONE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    // Limits are one below the cycle budget so the timeout edge lands exactly on the budget.
    localparam logic [CW-1:0] ACK_LIM  = CW'(ACK_CYCLES - 1);
    localparam logic [CW-1:0] DONE_LIM = CW'(DONE_CYCLES - 1);

    localparam logic [5:0] CMD_IDLE  = 6'b000000;
    localparam logic [5:0] CMD_INIT  = 6'b000001;
    localparam logic [5:0] CMD_SEND  = 6'b000100;
    localparam logic [5:0] CMD_CLEAR = 6'b001000;

    state_t        state_r, state_next_s;
    logic [CW-1:0] cnt_r;
    logic          gnt0_s, gnt1_s, done_s, tmo_s, boot_set_s, op_next_s;
    logic          gnt0_r, gnt1_r, done_r, done_id_r, err_r, boot_ok_r, op_r, last_r;
    logic [5:0]    cmd_out_r;
    logic [7:0]    data_out_r;

    function automatic logic [5:0] cmd_of(input state_t s, input logic op);
        case (s)
            S_BOOT_ISSUE, S_BOOT_WAIT:         cmd_of = CMD_INIT;
            S_ISSUE, S_WAIT_ACK, S_WAIT_DONE:  cmd_of = op ? CMD_CLEAR : CMD_SEND;
            default:                           cmd_of = CMD_IDLE;
        endcase
    endfunction

    // Next-state, grant and completion decode.
    always_comb begin
        state_next_s = state_r;
        gnt0_s       = 1'b0;
        gnt1_s       = 1'b0;
        done_s       = 1'b0;
        tmo_s        = 1'b0;
        boot_set_s   = 1'b0;
        case (state_r)
            S_BOOT_ISSUE: begin
                if (!ctrl_rdy) begin
                    state_next_s = S_BOOT_WAIT;
                end else if (cnt_r >= ACK_LIM) begin
                    state_next_s = S_RELEASE;
                    tmo_s        = 1'b1;
                end else begin
                    state_next_s = S_BOOT_ISSUE;
                end
            end
            S_BOOT_WAIT: begin
                if (ctrl_rdy) begin
                    state_next_s = S_RELEASE;
                    boot_set_s   = 1'b1;
                end else if (cnt_r >= DONE_LIM) begin
                    state_next_s = S_RELEASE;
                    tmo_s        = 1'b1;
                end else begin
                    state_next_s = S_BOOT_WAIT;
                end
            end
            S_IDLE: begin
                // last_r = 1 means client 1 was served last, so client 0 has priority.
                gnt0_s = req0 & (~req1 | last_r);
                gnt1_s = req1 & ~gnt0_s;
                if (req0 | req1) begin
                    state_next_s = S_ISSUE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_next_s = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!ctrl_rdy) begin
                    state_next_s = S_WAIT_DONE;
                end else if (cnt_r >= ACK_LIM) begin
                    state_next_s = S_RELEASE;
                    tmo_s        = 1'b1;
                    done_s       = 1'b1;
                end else begin
                    state_next_s = S_WAIT_ACK;
                end
            end
            S_WAIT_DONE: begin
                if (ctrl_rdy) begin
                    state_next_s = S_RELEASE;
                    done_s       = 1'b1;
                end else if (cnt_r >= DONE_LIM) begin
                    state_next_s = S_RELEASE;
                    tmo_s        = 1'b1;
                    done_s       = 1'b1;
                end else begin
                    state_next_s = S_WAIT_DONE;
                end
            end
            S_RELEASE: begin
                // A failed boot loops back to retry INIT instead of opening for clients.
                if (boot_ok_r) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_BOOT_ISSUE;
                end
            end
            default: begin
                state_next_s = S_BOOT_ISSUE;
            end
        endcase
    end

    // Operation selected for the command about to be issued.
    always_comb begin
        op_next_s = op_r;
        if (gnt0_s) begin
            op_next_s = op0;
        end else if (gnt1_s) begin
            op_next_s = op1;
        end else begin
            op_next_s = op_r;
        end
    end

    // State register and saturating per-state cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_BOOT_ISSUE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_next_s != state_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r != {CW{1'b1}}) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Registered outputs, latched request payload and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_out_r  <= CMD_IDLE;
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            done_r     <= 1'b0;
            done_id_r  <= 1'b0;
            err_r      <= 1'b0;
            boot_ok_r  <= 1'b0;
            data_out_r <= 8'h00;
            op_r       <= 1'b0;
            last_r     <= 1'b1;
        end else begin
            cmd_out_r <= cmd_of(state_next_s, op_next_s);
            gnt0_r    <= gnt0_s;
            gnt1_r    <= gnt1_s;
            done_r    <= done_s;
            done_id_r <= done_s & last_r;
            if (tmo_s) begin
                err_r <= 1'b1;
            end
            if (boot_set_s) begin
                boot_ok_r <= 1'b1;
            end
            if (gnt0_s | gnt1_s) begin
                data_out_r <= gnt0_s ? data0 : data1;
                op_r       <= op_next_s;
                last_r     <= gnt1_s;
            end
        end
    end

    assign gnt0     = gnt0_r;
    assign gnt1     = gnt1_r;
    assign done     = done_r;
    assign done_id  = done_id_r;
    assign err      = err_r;
    assign boot_ok  = boot_ok_r;
    assign cmd_out  = cmd_out_r;
    assign data_out = data_out_r;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed bench for lcd_cmd_sched: boot, single and round-robin commands,
// acknowledge timeout, mid-command reset and boot timeout.
module tb_lcd_cmd_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, op0, op1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, ctrl_rdy;
    logic [5:0] cmd_out;
    logic [7:0] data_out;
    logic       done, done_id, err, boot_ok;

    int tests = 0;
    int fails = 0;
    int gnt_seen;
    int init_bad;

    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_INIT  = 6'b000001;
    localparam logic [5:0] C_SEND  = 6'b000100;
    localparam logic [5:0] C_CLEAR = 6'b001000;

    lcd_cmd_sched #(.ACK_CYCLES(8), .DONE_CYCLES(200000)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .ctrl_rdy(ctrl_rdy),
        .cmd_out(cmd_out), .data_out(data_out),
        .done(done), .done_id(done_id), .err(err), .boot_ok(boot_ok)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one command starting in IDLE with requests already driven.
    task automatic run_cmd(input logic id, input logic [5:0] cmd, input logic [7:0] dat, input logic keep);
        tick();
        chk("gnt0", {31'd0, gnt0}, {31'd0, ~id});
        chk("gnt1", {31'd0, gnt1}, {31'd0, id});
        chk("cmd_issue", {26'd0, cmd_out}, {26'd0, cmd});
        chk("data_out", {24'd0, data_out}, {24'd0, dat});
        if (!keep) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        tick();
        chk("gnt_once", {30'd0, gnt0, gnt1}, 32'd0);
        ctrl_rdy = 1'b0;
        tick();
        tick();
        chk("cmd_hold", {26'd0, cmd_out}, {26'd0, cmd});
        ctrl_rdy = 1'b1;
        tick();
        chk("done", {31'd0, done}, 32'd1);
        chk("done_id", {31'd0, done_id}, {31'd0, id});
        chk("cmd_release", {26'd0, cmd_out}, {26'd0, C_IDLE});
        tick();
        chk("done_single", {31'd0, done}, 32'd0);
        chk("cmd_gap", {26'd0, cmd_out}, {26'd0, C_IDLE});
    endtask

    initial begin
        rst = 1'b0; ctrl_rdy = 1'b1;
        req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00;
        tick();
        tick();
        chk("rst_cmd", {26'd0, cmd_out}, 32'd0);
        chk("rst_flags", {27'd0, gnt0, gnt1, done, err, boot_ok}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);

        // Boot: controller drops ready for 100 cycles; a request during boot must not be granted.
        rst = 1'b1;
        req0 = 1'b1;
        tick();
        chk("boot_init", {26'd0, cmd_out}, {26'd0, C_INIT});
        ctrl_rdy = 1'b0;
        gnt_seen = 0;
        init_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (gnt0 || gnt1) gnt_seen++;
            if (cmd_out !== C_INIT) init_bad++;
        end
        chk("boot_no_gnt", gnt_seen, 32'd0);
        chk("boot_init_hold", init_bad, 32'd0);
        chk("boot_ok_early", {31'd0, boot_ok}, 32'd0);
        req0 = 1'b0;
        ctrl_rdy = 1'b1;
        tick();
        chk("boot_ok", {31'd0, boot_ok}, 32'd1);
        chk("boot_release", {26'd0, cmd_out}, {26'd0, C_IDLE});
        chk("boot_err", {31'd0, err}, 32'd0);
        tick();

        // Single SEND_DATA from client 0.
        req0 = 1'b1; op0 = 1'b0; data0 = 8'h41;
        run_cmd(1'b0, C_SEND, 8'h41, 1'b0);

        // Put the round-robin pointer on client 1, then both requesting: 0,1,0,1.
        req1 = 1'b1; op1 = 1'b0; data1 = 8'h55;
        run_cmd(1'b1, C_SEND, 8'h55, 1'b0);
        req0 = 1'b1; op0 = 1'b0; data0 = 8'h30;
        req1 = 1'b1; op1 = 1'b1; data1 = 8'h31;
        run_cmd(1'b0, C_SEND, 8'h30, 1'b1);
        run_cmd(1'b1, C_CLEAR, 8'h31, 1'b1);
        run_cmd(1'b0, C_SEND, 8'h30, 1'b1);
        run_cmd(1'b1, C_CLEAR, 8'h31, 1'b0);

        // Acknowledge timeout: ready never drops after ISSUE.
        req0 = 1'b1; op0 = 1'b0; data0 = 8'h42;
        tick();
        chk("tmo_gnt", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_err_early", {31'd0, err}, 32'd0);
        chk("tmo_cmd_hold", {26'd0, cmd_out}, {26'd0, C_SEND});
        tick();
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_done", {31'd0, done}, 32'd1);
        chk("tmo_done_id", {31'd0, done_id}, 32'd0);
        chk("tmo_cmd", {26'd0, cmd_out}, {26'd0, C_IDLE});
        tick();
        req1 = 1'b1; op1 = 1'b1; data1 = 8'h77;
        run_cmd(1'b1, C_CLEAR, 8'h77, 1'b0);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Reset pulsed during WAIT_DONE.
        req0 = 1'b1; op0 = 1'b1; data0 = 8'h99;
        tick();
        req0 = 1'b0;
        tick();
        ctrl_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_cmd", {26'd0, cmd_out}, 32'd0);
        chk("mid_rst_flags", {27'd0, gnt0, gnt1, done, err, boot_ok}, 32'd0);
        chk("mid_rst_data", {24'd0, data_out}, 32'd0);
        ctrl_rdy = 1'b1;
        tick();
        chk("mid_rst_no_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        tick();
        chk("reboot_init", {26'd0, cmd_out}, {26'd0, C_INIT});
        ctrl_rdy = 1'b0;
        tick();
        tick();
        ctrl_rdy = 1'b1;
        tick();
        chk("reboot_ok", {31'd0, boot_ok}, 32'd1);
        tick();
        req0 = 1'b1; op0 = 1'b0; data0 = 8'h11;
        req1 = 1'b1; op1 = 1'b0; data1 = 8'h22;
        run_cmd(1'b0, C_SEND, 8'h11, 1'b0);

        // Boot with ready stuck high: INIT times out and is retried after one IDLE cycle.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("bto_err_early", {31'd0, err}, 32'd0);
        chk("bto_init", {26'd0, cmd_out}, {26'd0, C_INIT});
        tick();
        chk("bto_err", {31'd0, err}, 32'd1);
        chk("bto_boot_ok", {31'd0, boot_ok}, 32'd0);
        chk("bto_no_done", {31'd0, done}, 32'd0);
        chk("bto_gap", {26'd0, cmd_out}, {26'd0, C_IDLE});
        tick();
        chk("bto_retry", {26'd0, cmd_out}, {26'd0, C_INIT});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
